// File: rtl/tftp_tx_scheduler_if.sv
// Decoder-event and builder-handshake bundle for the TFTP TX session scheduler.
//   dec_valid/dec_tid/dec_block/dec_len : decoded RRQ/ACK event (level valid)
//   tx_req/tx_tid/tx_block/tx_len       : block send request toward the packet builder
//   tx_ack                              : builder accepted the request (1-cycle pulse)
// Modports: master = scheduler, slave = decoder/builder side.
interface tftp_tx_scheduler_if;
  logic        dec_valid;
  logic [15:0] dec_tid;
  logic [15:0] dec_block;
  logic [15:0] dec_len;
  logic        tx_req;
  logic [15:0] tx_tid;
  logic [15:0] tx_block;
  logic [15:0] tx_len;
  logic        tx_ack;

  modport master (
    input  dec_valid, dec_tid, dec_block, dec_len, tx_ack,
    output tx_req, tx_tid, tx_block, tx_len
  );

  modport slave (
    output dec_valid, dec_tid, dec_block, dec_len, tx_ack,
    input  tx_req, tx_tid, tx_block, tx_len
  );
endinterface

// File: rtl/tftp_tx_scheduler.sv
// TFTP TX session scheduler: opens/advances/closes sessions from decoded RRQ/ACK events,
// grants READY sessions round-robin to the packet builder and retransmits on timeout.
// Ports:
//   clk, reset          : clock, synchronous active-low reset
//   bus (master)        : decoder events in, tx_req/tx_tid/tx_block/tx_len out, tx_ack in
//   busy                : any session entry in use
//   sess_abort          : 1-cycle pulse, session dropped after MAX_RETRY timeouts
//   sess_drop           : 1-cycle pulse, RRQ rejected because the table is full
//   stat_done/stat_retx : saturating completion / retransmission counters
// Optional feature: define TFTP_SCHED_STATS_EN to build the counters; otherwise they read 0.
module tftp_tx_scheduler #(
  parameter int unsigned NSESS     = 4,
  parameter logic [23:0] TIMEOUT   = 24'd12500000,
  parameter int unsigned MAX_RETRY = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  tftp_tx_scheduler_if.master   bus,
  output logic                  busy,
  output logic                  sess_abort,
  output logic                  sess_drop,
  output logic [15:0]           stat_done,
  output logic [15:0]           stat_retx
);

  localparam int unsigned IdxW     = $clog2(NSESS);
  localparam int unsigned SumW     = IdxW + 1;
  localparam logic [7:0]  MaxRetry = 8'(MAX_RETRY);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NSESS - 1);

  typedef enum logic [1:0] {StFree, StReady, StWaitTx, StWaitAck} sess_st_e;

  sess_st_e    st_q    [NSESS];
  logic [15:0] tid_q   [NSESS];
  logic [15:0] blk_q   [NSESS];
  logic [15:0] len_q   [NSESS];
  logic [23:0] timer_q [NSESS];
  logic [7:0]  retry_q [NSESS];

  logic            dec_valid_q, ev_q;
  logic [15:0]     ev_tid_q, ev_blk_q, ev_len_q;
  logic            tx_req_q;
  logic [15:0]     tx_tid_q, tx_blk_q, tx_len_q;
  logic [IdxW-1:0] gnt_idx_q, rr_ptr_q;
  logic            abort_q, drop_q;

  logic            match_hit, free_hit, gnt_hit, busy_c;
  logic [IdxW-1:0] match_idx, free_idx, gnt_idx;
  logic [SumW-1:0] rr_sum;
  logic            ack_hit, alloc, drop_c;
  logic [NSESS-1:0] tmo;

  always_comb begin
    match_hit = 1'b0;
    match_idx = '0;
    free_hit  = 1'b0;
    free_idx  = '0;
    busy_c    = 1'b0;
    // Descending scan so the lowest index wins.
    for (int i = int'(NSESS) - 1; i >= 0; i--) begin
      if (st_q[i] != StFree) begin
        busy_c = 1'b1;
        if (tid_q[i] == ev_tid_q) begin
          match_hit = 1'b1;
          match_idx = IdxW'(i);
        end
      end else begin
        free_hit = 1'b1;
        free_idx = IdxW'(i);
      end
    end

    // Round-robin: smallest offset from the pointer wins.
    gnt_hit = 1'b0;
    gnt_idx = '0;
    rr_sum  = '0;
    for (int k = int'(NSESS) - 1; k >= 0; k--) begin
      rr_sum = {1'b0, rr_ptr_q} + SumW'(k);
      if (rr_sum >= SumW'(NSESS)) rr_sum = rr_sum - SumW'(NSESS);
      if (st_q[rr_sum[IdxW-1:0]] == StReady) begin
        gnt_hit = 1'b1;
        gnt_idx = rr_sum[IdxW-1:0];
      end
    end

    ack_hit = ev_q && match_hit && (st_q[match_idx] == StWaitAck) &&
              (ev_blk_q == blk_q[match_idx] + 16'd1);
    alloc   = ev_q && !match_hit && (ev_blk_q == 16'd1) && free_hit;
    drop_c  = ev_q && !match_hit && (ev_blk_q == 16'd1) && !free_hit;

    // A valid ACK landing on the expiry cycle suppresses the timeout.
    for (int i = 0; i < int'(NSESS); i++) begin
      tmo[i] = (st_q[i] == StWaitAck) && (timer_q[i] == 24'd0) &&
               !(ack_hit && (match_idx == IdxW'(i)));
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < int'(NSESS); i++) begin
        st_q[i]    <= StFree;
        tid_q[i]   <= '0;
        blk_q[i]   <= '0;
        len_q[i]   <= '0;
        timer_q[i] <= '0;
        retry_q[i] <= '0;
      end
      dec_valid_q <= 1'b0;
      ev_q        <= 1'b0;
      ev_tid_q    <= '0;
      ev_blk_q    <= '0;
      ev_len_q    <= '0;
      tx_req_q    <= 1'b0;
      tx_tid_q    <= '0;
      tx_blk_q    <= '0;
      tx_len_q    <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      abort_q     <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      dec_valid_q <= bus.dec_valid;
      ev_q        <= bus.dec_valid & ~dec_valid_q;
      if (bus.dec_valid && !dec_valid_q) begin
        ev_tid_q <= bus.dec_tid;
        ev_blk_q <= bus.dec_block;
        ev_len_q <= bus.dec_len;
      end
      abort_q <= 1'b0;
      drop_q  <= drop_c;

      for (int i = 0; i < int'(NSESS); i++) begin
        if (st_q[i] == StWaitAck && timer_q[i] != 24'd0) begin
          timer_q[i] <= timer_q[i] - 24'd1;
        end
        if (tmo[i]) begin
          retry_q[i] <= retry_q[i] + 8'd1;
          if (retry_q[i] + 8'd1 == MaxRetry) begin
            st_q[i] <= StFree;
            abort_q <= 1'b1;
          end else begin
            st_q[i] <= StReady;
          end
        end
      end

      if (ack_hit) begin
        if (len_q[match_idx] == 16'd0) begin
          st_q[match_idx] <= StFree;
        end else begin
          st_q[match_idx]    <= StReady;
          blk_q[match_idx]   <= ev_blk_q;
          len_q[match_idx]   <= ev_len_q;
          retry_q[match_idx] <= '0;
        end
      end

      if (alloc) begin
        st_q[free_idx]    <= StReady;
        tid_q[free_idx]   <= ev_tid_q;
        blk_q[free_idx]   <= 16'd1;
        len_q[free_idx]   <= ev_len_q;
        retry_q[free_idx] <= '0;
      end

      if (tx_req_q) begin
        if (bus.tx_ack) begin
          tx_req_q           <= 1'b0;
          st_q[gnt_idx_q]    <= StWaitAck;
          timer_q[gnt_idx_q] <= TIMEOUT;
          rr_ptr_q           <= (gnt_idx_q == LastIdx) ? '0 : gnt_idx_q + 1'b1;
        end
      end else if (gnt_hit) begin
        tx_req_q        <= 1'b1;
        gnt_idx_q       <= gnt_idx;
        tx_tid_q        <= tid_q[gnt_idx];
        tx_blk_q        <= blk_q[gnt_idx];
        tx_len_q        <= len_q[gnt_idx];
        st_q[gnt_idx]   <= StWaitTx;
      end
    end
  end

  assign bus.tx_req   = tx_req_q;
  assign bus.tx_tid   = tx_tid_q;
  assign bus.tx_block = tx_blk_q;
  assign bus.tx_len   = tx_len_q;
  assign busy         = busy_c;
  assign sess_abort   = abort_q;
  assign sess_drop    = drop_q;

`ifdef TFTP_SCHED_STATS_EN
  logic [15:0] done_q, retx_q;
  logic [3:0]  n_retx;
  logic [16:0] retx_sum;

  always_comb begin
    n_retx = '0;
    for (int i = 0; i < int'(NSESS); i++) begin
      if (tmo[i] && (retry_q[i] + 8'd1 != MaxRetry)) n_retx = n_retx + 4'd1;
    end
    retx_sum = {1'b0, retx_q} + 17'(n_retx);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      done_q <= '0;
      retx_q <= '0;
    end else begin
      if (ack_hit && len_q[match_idx] == 16'd0 && done_q != 16'hFFFF) begin
        done_q <= done_q + 16'd1;
      end
      retx_q <= retx_sum[16] ? 16'hFFFF : retx_sum[15:0];
    end
  end

  assign stat_done = done_q;
  assign stat_retx = retx_q;
`else
  assign stat_done = 16'h0;
  assign stat_retx = 16'h0;
`endif

endmodule
